window_3x3_sweeper: RTL and testbench
=====================================

Name: window_3x3_sweeper

Overview:
- Downstream of the three-row line buffer.
- On each valid row triple it captures the three W-wide, K-channel rows, then sweeps a 3x3 window across them one column per handshake.
- Emits one 3x3xK window per accepted transfer to the convolution/pooling PE array.
- Converts a one-shot wide row burst into a ready/valid window stream.

Parameters:
- DATA_BITS, 8, bits per pixel element.
- W, 24, row width in pixels.
- K, 6, channels per pixel.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- row_1  input  W*DATA_BITS*K  oldest (top) row; pixel c, channel k at bits [(c*K+k)*DATA_BITS +: DATA_BITS].
- row_2  input  W*DATA_BITS*K  middle row, same packing.
- row_3  input  W*DATA_BITS*K  newest (bottom) row, same packing.
- valid_i  input  1  single-cycle pulse: row_1..row_3 valid.
- in_ready  output  1  block can accept valid_i this cycle.
- win_data  output  9*K*DATA_BITS  window; element (r,dc,k) at [((r*3+dc)*K+k)*DATA_BITS +: DATA_BITS], r=0 is row_1, dc=0 is leftmost.
- win_col  output  $clog2(W)  centre-column index of the current window.
- win_valid  output  1  win_data/win_col valid.
- win_ready  input  1  downstream accepts the window.
- done_o  output  1  one-cycle pulse after the last window of a sweep is accepted.
- overflow  output  1  sticky: valid_i arrived while in_ready=0.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, col counter=0, captured rows=0.
  - win_valid=0, done_o=0, overflow=0, in_ready=1, win_col=0, win_data=0.
- Reset mid-sweep discards all remaining windows. No done_o is generated.
- Sweep length N:
  - No padding: N=W-2; window n uses columns n..n+2; win_col=n+1.
- State IDLE:
  - in_ready=1, win_valid=0.
  - valid_i=1: capture all three rows at the edge, col=0, go to SWEEP.
- State SWEEP:
  - win_valid=1. win_data is a registered-row mux indexed by col, so it is stable while win_valid=1 and win_ready=0.
  - win_valid=1 and win_ready=1, col<N-1: col++.
  - Handshake on col=N-1 (last window):
    - done_o=1 next cycle.
    - valid_i=0: go to IDLE.
    - valid_i=1 in the same cycle: capture new rows, col=0, stay in SWEEP. There is no bubble; done_o still pulses.
- in_ready = IDLE or (SWEEP and col=N-1 and win_ready).
- Latency: valid_i accepted at edge t gives first win_valid=1 in cycle t+1. With win_ready tied high, N windows follow on consecutive cycles.
- Overflow:
  - valid_i=1 while in_ready=0: the data is dropped and overflow is set.
  - overflow clears only on reset.
  - Capture registers, state and sweep are unaffected.
- No arithmetic on data. The column counter saturates at N-1 and never wraps beyond it.
- win_valid never deasserts without a handshake, except on reset.

Optional Feature:
- Macro: WINDOW_ZERO_PAD_EN.
- Defined:
  - N=W; window n uses columns n-1..n+1; win_col=n.
  - Column -1 and column W read as zero for all rows and channels.
  - Output width, handshake and state machine are unchanged.
- Undefined: N=W-2, no padding logic is built, and win_col=n+1.

Test Plan:
- Reset, then one valid_i with element value = (r*64+c*2+k) mod 256, win_ready=1.
  - Expect win_valid from the next cycle for exactly 22 cycles.
  - Window 0 element (r=1,dc=2,k=3) = 64+4+3 = 71, win_col=1.
  - Last window has win_col=22.
  - done_o pulses once; in_ready=1 afterwards.
- Backpressure: win_ready toggling 1,0,0,1,...
  - win_data and win_col hold during stalls.
  - All 22 windows are delivered in order, none skipped or duplicated.
- Back-to-back: second valid_i coincides with the handshake of window 21.
  - The next cycle shows window 0 of the new rows, win_col=1.
  - done_o=1 in that cycle; overflow=0.
- Overflow: valid_i at window 5 of a sweep.
  - overflow=1 and stays 1.
  - Remaining windows 6..21 still carry the first rows' data.
- Reset asserted at window 10.
  - All outputs go to reset values immediately; no done_o.
  - The next valid_i starts a fresh sweep at win_col=1.
- With WINDOW_ZERO_PAD_EN: 24 windows.
  - Window 0 column dc=0 is all zero; window 23 column dc=2 is all zero.
  - Window 0 element (r=0,dc=1,k=0) = 0 (pixel c=0); win_col runs 0..23.

Source files
------------

// File: rtl/window_3x3_sweeper_if.sv
// ---------------------------------------------------------------------------
// window_3x3_sweeper_if
//
// Window output stream from the 3x3 sweeper to the PE array.
//
// Signals:
//   win_data   9*K*DATA_BITS  window; element (r,dc,k) at
//                             [((r*3+dc)*K+k)*DATA_BITS +: DATA_BITS]
//   win_col    COL_BITS       centre-column index of the current window
//   win_valid  1              win_data/win_col valid
//   win_ready  1              consumer accepts the window
//   done_o     1              one-cycle pulse after the last window of a sweep
//
// Modports:
//   master  the sweeper (drives window, valid, done; samples ready)
//   slave   the consumer (samples window, valid, done; drives ready)
// ---------------------------------------------------------------------------
interface window_3x3_sweeper_if #(
  parameter int DATA_BITS = 8,
  parameter int W         = 24,
  parameter int K         = 6
) ();

  localparam int COL_BITS = (W > 1) ? $clog2(W) : 1;
  localparam int WIN_BITS = 9 * K * DATA_BITS;

  logic [WIN_BITS-1:0] win_data;
  logic [COL_BITS-1:0] win_col;
  logic                win_valid;
  logic                win_ready;
  logic                done_o;

  modport master (
    output win_data,
    output win_col,
    output win_valid,
    output done_o,
    input  win_ready
  );

  modport slave (
    input  win_data,
    input  win_col,
    input  win_valid,
    input  done_o,
    output win_ready
  );

endinterface

// File: rtl/window_3x3_sweeper.sv
// ---------------------------------------------------------------------------
// window_3x3_sweeper
//
// Sits behind the three-row line buffer. A single-cycle valid_i captures the
// three W-pixel, K-channel rows; the block then slides a 3x3 window across
// the captured rows, one column per accepted transfer, and hands each
// 3x3xK window to the PE array through a ready/valid stream.
//
// Ports:
//   clk        input   rising-edge clock
//   resetn     input   asynchronous active-low reset
//   row_1      input   oldest (top) row; pixel c, channel k at
//                      [(c*K+k)*DATA_BITS +: DATA_BITS]
//   row_2      input   middle row, same packing
//   row_3      input   newest (bottom) row, same packing
//   valid_i    input   single-cycle pulse, row_1..row_3 valid
//   in_ready   output  a valid_i this cycle will be taken
//   overflow   output  sticky, set when valid_i arrives while in_ready=0
//   win        master  window stream (win_data, win_col, win_valid,
//                      win_ready, done_o)
//
// Configuration:
//   WINDOW_ZERO_PAD_EN  when defined, the sweep covers all W centre columns
//                       and the out-of-row neighbours (columns -1 and W)
//                       read as zero; win_col is then the window index.
//                       When undefined, only the W-2 fully interior windows
//                       are produced and win_col is window index + 1.
// ---------------------------------------------------------------------------
module window_3x3_sweeper #(
  parameter int DATA_BITS = 8,
  parameter int W         = 24,
  parameter int K         = 6
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [W*DATA_BITS*K-1:0]   row_1,
  input  logic [W*DATA_BITS*K-1:0]   row_2,
  input  logic [W*DATA_BITS*K-1:0]   row_3,
  input  logic                       valid_i,
  output logic                       in_ready,
  output logic                       overflow,
  window_3x3_sweeper_if.master       win
);

  localparam int ROW_BITS = W * DATA_BITS * K;
  localparam int WIN_BITS = 9 * K * DATA_BITS;
  localparam int COL_BITS = (W > 1) ? $clog2(W) : 1;

`ifdef WINDOW_ZERO_PAD_EN
  localparam int N = W;
`else
  localparam int N = W - 2;
`endif

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [COL_BITS-1:0] col_q;
  logic [ROW_BITS-1:0] rows_q [3];
  logic                done_q;
  logic                overflow_q;

  logic                last_col;
  logic                handshake;
  logic                accept;
  logic                in_ready_c;
  logic                win_valid_c;
  logic [WIN_BITS-1:0] win_data_c;
  logic [COL_BITS-1:0] win_col_c;
  int                  pix_idx;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode. A new row triple can only be taken when
  // idle or in the very cycle the last window is handed off, which lets
  // consecutive sweeps run without a bubble.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    win_valid_c = 1'b0;
    handshake   = 1'b0;
    last_col    = (col_q == LAST_COL);
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (valid_i) begin
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        win_valid_c = 1'b1;
        handshake   = win.win_ready;
        if (handshake && last_col) begin
          in_ready_c = 1'b1;
          state_d    = valid_i ? SWEEP : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    accept = valid_i && in_ready_c;
  end

  // Row capture and column counter. The counter stops at the last window;
  // leaving that column only happens through a fresh capture or reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q     <= '0;
      rows_q[0] <= '0;
      rows_q[1] <= '0;
      rows_q[2] <= '0;
    end else if (accept) begin
      col_q     <= '0;
      rows_q[0] <= row_1;
      rows_q[1] <= row_2;
      rows_q[2] <= row_3;
    end else if (handshake && !last_col) begin
      col_q <= col_q + COL_BITS'(1);
    end
  end

  // Sweep-complete pulse and sticky overflow flag. A dropped valid_i does
  // not disturb the capture registers or the sweep in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q     <= handshake && last_col;
      overflow_q <= overflow_q | (valid_i & ~in_ready_c);
    end
  end

  // Window mux straight off the captured rows, so the window holds steady
  // for as long as the consumer stalls. Outside a sweep it reads zero.
  always_comb begin
    win_data_c = '0;
    pix_idx    = 0;
    if (state_q == SWEEP) begin
      for (int r = 0; r < 3; r++) begin
        for (int dc = 0; dc < 3; dc++) begin
`ifdef WINDOW_ZERO_PAD_EN
          pix_idx = int'(col_q) + dc - 1;
`else
          pix_idx = int'(col_q) + dc;
`endif
          // Columns outside the row contribute zeros (only reachable
          // with padding enabled).
          if (pix_idx >= 0 && pix_idx < W) begin
            for (int k = 0; k < K; k++) begin
              win_data_c[((r*3+dc)*K+k)*DATA_BITS +: DATA_BITS] =
                rows_q[r][(pix_idx*K+k)*DATA_BITS +: DATA_BITS];
            end
          end
        end
      end
    end
  end

  // Centre-column index reported alongside the window.
  always_comb begin
    win_col_c = '0;
    if (state_q == SWEEP) begin
`ifdef WINDOW_ZERO_PAD_EN
      win_col_c = col_q;
`else
      win_col_c = col_q + COL_BITS'(1);
`endif
    end
  end

  assign in_ready      = in_ready_c;
  assign overflow      = overflow_q;
  assign win.win_valid = win_valid_c;
  assign win.win_data  = win_data_c;
  assign win.win_col   = win_col_c;
  assign win.done_o    = done_q;

endmodule

// File: tb/tb_window_3x3_sweeper.sv
// ---------------------------------------------------------------------------
// tb_window_3x3_sweeper
//
// Drives window_3x3_sweeper with directed and randomized row triples and
// compares every cycle against a transaction-level reference: each accepted
// row triple expands into the full list of expected windows, which the
// consumer side pops as handshakes occur.
// ---------------------------------------------------------------------------
module tb_window_3x3_sweeper;

  localparam int DATA_BITS = 8;
  localparam int W         = 24;
  localparam int K         = 6;
  localparam int ROW_BITS  = W * DATA_BITS * K;
  localparam int WIN_BITS  = 9 * K * DATA_BITS;

`ifdef WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int N   = W;
`else
  localparam bit PAD = 1'b0;
  localparam int N   = W - 2;
`endif

  logic                clk = 1'b0;
  logic                resetn;
  logic [ROW_BITS-1:0] row_1;
  logic [ROW_BITS-1:0] row_2;
  logic [ROW_BITS-1:0] row_3;
  logic                valid_i;
  logic                in_ready;
  logic                overflow;

  window_3x3_sweeper_if #(.DATA_BITS(DATA_BITS), .W(W), .K(K)) win_if ();

  window_3x3_sweeper #(.DATA_BITS(DATA_BITS), .W(W), .K(K)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .row_1    (row_1),
    .row_2    (row_2),
    .row_3    (row_3),
    .valid_i  (valid_i),
    .in_ready (in_ready),
    .overflow (overflow),
    .win      (win_if)
  );

  always #5 clk = ~clk;

  // Reference state: pixel arrays and the list of windows still owed.
  logic [DATA_BITS-1:0] pix [3][W][K];
  logic [WIN_BITS-1:0]  exp_data_q [$];
  int                   exp_col_q  [$];
  bit                   exp_last_q [$];
  bit                   exp_done;
  bit                   exp_ovf;
  int                   compared;
  int                   mismatched;

  task automatic checkOutput(input string tag, input logic [WIN_BITS-1:0] observed,
                             input logic [WIN_BITS-1:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [ROW_BITS-1:0] packRow(input int r);
    logic [ROW_BITS-1:0] v;
    v = '0;
    for (int c = 0; c < W; c++)
      for (int k = 0; k < K; k++)
        v[(c*K+k)*DATA_BITS +: DATA_BITS] = pix[r][c][k];
    return v;
  endfunction

  // Window n straight from the pixel arrays: centre column is n (padded) or
  // n+1 (interior only); anything off the row edge is zero.
  function automatic logic [WIN_BITS-1:0] expWindow(input int n);
    logic [WIN_BITS-1:0] e;
    int p;
    e = '0;
    for (int r = 0; r < 3; r++)
      for (int dc = 0; dc < 3; dc++) begin
        p = PAD ? n + dc - 1 : n + dc;
        for (int k = 0; k < K; k++)
          e[((r*3+dc)*K+k)*DATA_BITS +: DATA_BITS] =
            (p < 0 || p >= W) ? '0 : pix[r][p][k];
      end
    return e;
  endfunction

  task automatic driveRows();
    row_1 = packRow(0);
    row_2 = packRow(1);
    row_3 = packRow(2);
  endtask

  task automatic setPattern();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < K; k++)
          pix[r][c][k] = DATA_BITS'((r*64 + c*2 + k) % 256);
    driveRows();
  endtask

  task automatic setRandom();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < K; k++)
          pix[r][c][k] = DATA_BITS'($urandom_range(0, 255));
    driveRows();
  endtask

  task automatic pushSweep();
    for (int n = 0; n < N; n++) begin
      exp_data_q.push_back(expWindow(n));
      exp_col_q.push_back(PAD ? n : n + 1);
      exp_last_q.push_back(n == N - 1);
    end
  endtask

  // Compare this cycle's outputs with the reference, then advance the
  // reference across the coming clock edge.
  task automatic modelStep();
    bit exp_in_ready;
    bit hs;
    if (!resetn) begin
      exp_data_q.delete();
      exp_col_q.delete();
      exp_last_q.delete();
      exp_done = 1'b0;
      exp_ovf  = 1'b0;
      checkOutput("rst_win_valid", win_if.win_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_done", win_if.done_o, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_win_col", win_if.win_col, 0);
      checkOutput("rst_win_data", win_if.win_data, 0);
      return;
    end
    exp_in_ready = (exp_data_q.size() == 0) ||
                   (exp_data_q.size() == 1 && win_if.win_ready);
    checkOutput("win_valid", win_if.win_valid, exp_data_q.size() != 0);
    checkOutput("in_ready", in_ready, exp_in_ready);
    checkOutput("done_o", win_if.done_o, exp_done);
    checkOutput("overflow", overflow, exp_ovf);
    if (exp_data_q.size() != 0) begin
      checkOutput("win_data", win_if.win_data, exp_data_q[0]);
      checkOutput("win_col", win_if.win_col, exp_col_q[0]);
    end
    hs       = (exp_data_q.size() != 0) && win_if.win_ready;
    exp_done = hs && exp_last_q[0];
    if (hs) begin
      void'(exp_data_q.pop_front());
      void'(exp_col_q.pop_front());
      void'(exp_last_q.pop_front());
    end
    if (valid_i) begin
      if (exp_in_ready) pushSweep();
      else exp_ovf = 1'b1;
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are
  // checked on the falling edge.
  task automatic applyStimulus(input bit v, input bit rdy);
    valid_i          = v;
    win_if.win_ready = rdy;
    @(negedge clk);
    modelStep();
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (exp_data_q.size() != 0 && i < budget) begin
      applyStimulus(1'b0, 1'b1);
      i++;
    end
    checkOutput("drain_left", exp_data_q.size(), 0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
  endtask

  initial begin
    logic [WIN_BITS-1:0] w;
    int guard;
    int windows;
    compared   = 0;
    mismatched = 0;
    exp_done   = 1'b0;
    exp_ovf    = 1'b0;
    resetn     = 1'b0;
    valid_i    = 1'b0;
    win_if.win_ready = 1'b0;
    row_1 = '0;
    row_2 = '0;
    row_3 = '0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b1);

    // Single sweep of the reference pattern with the consumer always ready.
    $display("[TB] single sweep");
    setPattern();
    applyStimulus(1'b1, 1'b1);
    w = win_if.win_data;
    if (PAD) begin
      checkOutput("w0_col", win_if.win_col, 0);
      checkOutput("w0_r0dc1k0", w[((0*3+1)*K+0)*DATA_BITS +: DATA_BITS], 0);
      checkOutput("w0_r1dc0k2", w[((1*3+0)*K+2)*DATA_BITS +: DATA_BITS], 0);
    end else begin
      checkOutput("w0_col", win_if.win_col, 1);
      checkOutput("w0_r1dc2k3", w[((1*3+2)*K+3)*DATA_BITS +: DATA_BITS], 71);
    end
    windows = 0;
    guard   = 0;
    while (win_if.win_valid && guard < 3 * N) begin
      applyStimulus(1'b0, 1'b1);
      windows++;
      guard++;
    end
    checkOutput("sweep_len", windows, N);
    drain(4 * N);

    // Consumer stalls in a 1,0,0 pattern.
    $display("[TB] backpressure");
    setRandom();
    applyStimulus(1'b1, 1'b1);
    guard = 0;
    while (exp_data_q.size() != 0 && guard < 6 * N) begin
      applyStimulus(1'b0, (guard % 3) == 0);
      guard++;
    end
    drain(4 * N);

    // Second row triple lands on the last window's handshake.
    $display("[TB] back-to-back");
    setRandom();
    applyStimulus(1'b1, 1'b1);
    guard = 0;
    while (exp_data_q.size() > 1 && guard < 3 * N) begin
      applyStimulus(1'b0, 1'b1);
      guard++;
    end
    setRandom();
    applyStimulus(1'b1, 1'b1);
    checkOutput("b2b_col", win_if.win_col, PAD ? 0 : 1);
    checkOutput("b2b_done", win_if.done_o, 1);
    checkOutput("b2b_overflow", overflow, 0);
    drain(4 * N);

    // Row triple offered mid-sweep is dropped.
    $display("[TB] overflow");
    setRandom();
    applyStimulus(1'b1, 1'b1);
    guard = 0;
    while (exp_data_q.size() > N - 5 && guard < 3 * N) begin
      applyStimulus(1'b0, 1'b1);
      guard++;
    end
    setRandom();
    applyStimulus(1'b1, 1'b1);
    checkOutput("ovf_set", overflow, 1);
    drain(4 * N);
    checkOutput("ovf_sticky", overflow, 1);

    // Reset in the middle of a sweep.
    $display("[TB] reset mid-sweep");
    setRandom();
    applyStimulus(1'b1, 1'b1);
    guard = 0;
    while (exp_data_q.size() > N - 10 && guard < 3 * N) begin
      applyStimulus(1'b0, 1'b1);
      guard++;
    end
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_valid", win_if.win_valid, 0);
    checkOutput("mid_rst_ovf", overflow, 0);
    checkOutput("mid_rst_col", win_if.win_col, 0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b1);
    setRandom();
    applyStimulus(1'b1, 1'b1);
    checkOutput("post_rst_col", win_if.win_col, PAD ? 0 : 1);
    drain(4 * N);

    // Random traffic: occasional row triples, random consumer stalls.
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        setRandom();
        applyStimulus(1'b1, $urandom_range(0, 3) != 0);
      end else begin
        applyStimulus(1'b0, $urandom_range(0, 3) != 0);
      end
    end
    drain(4 * N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
